// File: rtl/std_seq_mem_d3_if.sv
// ----------------------------------------------------------------------------
// std_seq_mem_d3_if
//
// Access bus for the std_seq_mem_d3 sequential-read 3-D memory. A requester
// presents a 3-D index together with content_en/write_en/write_data. The
// memory answers one cycle later with done, oob_error and read_data.
//
// Signals:
//   addr0      [D0_IDX_SIZE-1:0]  dimension-0 index            (master -> slave)
//   addr1      [D1_IDX_SIZE-1:0]  dimension-1 index            (master -> slave)
//   addr2      [D2_IDX_SIZE-1:0]  dimension-2 index            (master -> slave)
//   content_en                    access request strobe         (master -> slave)
//   write_en                      1 = write, 0 = read           (master -> slave)
//   write_data [WIDTH-1:0]        data for writes               (master -> slave)
//   read_data  [WIDTH-1:0]        registered read result        (slave -> master)
//   done                          completion pulse per access   (slave -> master)
//   oob_error                     access was out of bounds      (slave -> master)
//
// Modports:
//   master : the requester (control FSM or testbench)
//   slave  : the memory
// ----------------------------------------------------------------------------
interface std_seq_mem_d3_if #(
    parameter int WIDTH       = 32,
    parameter int D0_IDX_SIZE = 4,
    parameter int D1_IDX_SIZE = 4,
    parameter int D2_IDX_SIZE = 4
);

    logic [D0_IDX_SIZE-1:0] addr0;
    logic [D1_IDX_SIZE-1:0] addr1;
    logic [D2_IDX_SIZE-1:0] addr2;
    logic                   content_en;
    logic                   write_en;
    logic [WIDTH-1:0]       write_data;
    logic [WIDTH-1:0]       read_data;
    logic                   done;
    logic                   oob_error;

    modport master (
        output addr0,
        output addr1,
        output addr2,
        output content_en,
        output write_en,
        output write_data,
        input  read_data,
        input  done,
        input  oob_error
    );

    modport slave (
        input  addr0,
        input  addr1,
        input  addr2,
        input  content_en,
        input  write_en,
        input  write_data,
        output read_data,
        output done,
        output oob_error
    );

endinterface

// File: rtl/std_seq_mem_d3.sv
// ----------------------------------------------------------------------------
// std_seq_mem_d3
//
// Parametrised 3-D memory with a registered read port, a content_en/done
// handshake and out-of-bounds detection. Dimension sizes may be any value,
// including non-powers of two. One access is accepted on every rising edge
// where content_en is high; its result (done, oob_error, read_data) is
// visible during the following cycle.
//
// Ports:
//   clk      sole clock, rising edge active
//   reset_n  asynchronous active-low reset; clears read_data/done/oob_error
//            immediately and blocks all accesses while low. The storage array
//            itself is not reset.
//   bus      std_seq_mem_d3_if.slave access bus (addr0/1/2, content_en,
//            write_en, write_data in; read_data, done, oob_error out)
// ----------------------------------------------------------------------------
module std_seq_mem_d3 #(
    parameter int WIDTH       = 32,
    parameter int D0_SIZE     = 16,
    parameter int D1_SIZE     = 16,
    parameter int D2_SIZE     = 16,
    parameter int D0_IDX_SIZE = 4,
    parameter int D1_IDX_SIZE = 4,
    parameter int D2_IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    std_seq_mem_d3_if.slave     bus
);

    localparam int SIZE          = D0_SIZE * D1_SIZE * D2_SIZE;
    localparam int FLAT_IDX_SIZE = (SIZE > 1) ? $clog2(SIZE) : 1;

    // Index arithmetic is done at a fixed wide width so that an out-of-range
    // addr0 can never wrap back into the valid range before the bounds check.
    localparam int CALC_W = 64;

    localparam logic [CALC_W-1:0] D0_LIM = CALC_W'(D0_SIZE);
    localparam logic [CALC_W-1:0] D1_LIM = CALC_W'(D1_SIZE);
    localparam logic [CALC_W-1:0] D2_LIM = CALC_W'(D2_SIZE);
    localparam logic [CALC_W-1:0] SIZE_LIM = CALC_W'(SIZE);

    logic [WIDTH-1:0] mem [SIZE];

    logic [CALC_W-1:0]        addr0_w;
    logic [CALC_W-1:0]        addr1_w;
    logic [CALC_W-1:0]        addr2_w;
    logic [CALC_W-1:0]        flat_full;
    logic                     in_bounds;
    logic [FLAT_IDX_SIZE-1:0] flat_idx;
    logic                     accept_write;
    logic                     accept_read;

    // Address decode: widen each index, form the flattened row-major index
    // (addr0 outermost, addr2 innermost) and decide whether the access lands
    // inside the array.
    always_comb begin
        addr0_w   = CALC_W'(bus.addr0);
        addr1_w   = CALC_W'(bus.addr1);
        addr2_w   = CALC_W'(bus.addr2);
        flat_full = (addr0_w * D1_LIM + addr1_w) * D2_LIM + addr2_w;
        // The per-dimension checks define out-of-bounds; the flat check can
        // only fail when they already have, and keeps the array index provably
        // in range.
        in_bounds = (addr0_w < D0_LIM) &&
                    (addr1_w < D1_LIM) &&
                    (addr2_w < D2_LIM) &&
                    (flat_full < SIZE_LIM);
        // Out-of-bounds accesses are steered to entry 0 so the array is never
        // indexed past its end, even on a path whose result is discarded.
        flat_idx  = in_bounds ? flat_full[FLAT_IDX_SIZE-1:0] : '0;
    end

    // Access qualification: write_en only matters when content_en is high.
    always_comb begin
        accept_write = bus.content_en &&  bus.write_en;
        accept_read  = bus.content_en && !bus.write_en;
    end

    // Storage array. It has no reset, so reset_n is used here as a plain
    // enable: writes presented while reset is held are dropped.
    always_ff @(posedge clk) begin
        if (reset_n && accept_write && in_bounds) begin
            mem[flat_idx] <= bus.write_data;
        end
    end

    // Response registers. done and oob_error are re-evaluated every edge so
    // they form single-cycle pulses per access; read_data only moves on an
    // accepted read and holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.read_data <= '0;
            bus.done      <= 1'b0;
            bus.oob_error <= 1'b0;
        end else begin
            bus.done      <= bus.content_en;
            bus.oob_error <= bus.content_en && !in_bounds;
            if (accept_read) begin
                bus.read_data <= in_bounds ? mem[flat_idx] : '0;
            end
        end
    end

endmodule

// File: tb/tb_std_seq_mem_d3.sv
// ----------------------------------------------------------------------------
// tb_std_seq_mem_d3
//
// Drives the same access stream into two memories: one with the default
// 16x16x16 geometry and one with a 12x16x10 geometry, so that one address
// can be in bounds for the first and out of bounds for the second. A
// reference model per memory computes the response for every edge and pushes
// it into a queue; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_std_seq_mem_d3;

    localparam int WIDTH = 32;
    localparam int IDXW  = 4;

    typedef struct packed {
        logic             done;
        logic             oob;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk;
    logic reset_n;

    logic             cen;
    logic             wen;
    logic [IDXW-1:0]  a0;
    logic [IDXW-1:0]  a1;
    logic [IDXW-1:0]  a2;
    logic [WIDTH-1:0] wd;

    int checks;
    int errors;

    int d0s [2];
    int d1s [2];
    int d2s [2];
    logic [WIDTH-1:0] model_mem [2][4096];
    logic [WIDTH-1:0] model_rd  [2];

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    std_seq_mem_d3_if #(.WIDTH(WIDTH), .D0_IDX_SIZE(IDXW), .D1_IDX_SIZE(IDXW), .D2_IDX_SIZE(IDXW)) bus_a ();
    std_seq_mem_d3_if #(.WIDTH(WIDTH), .D0_IDX_SIZE(IDXW), .D1_IDX_SIZE(IDXW), .D2_IDX_SIZE(IDXW)) bus_b ();

    std_seq_mem_d3 #(
        .WIDTH(WIDTH), .D0_SIZE(16), .D1_SIZE(16), .D2_SIZE(16),
        .D0_IDX_SIZE(IDXW), .D1_IDX_SIZE(IDXW), .D2_IDX_SIZE(IDXW)
    ) dut_a (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_a.slave)
    );

    std_seq_mem_d3 #(
        .WIDTH(WIDTH), .D0_SIZE(12), .D1_SIZE(16), .D2_SIZE(10),
        .D0_IDX_SIZE(IDXW), .D1_IDX_SIZE(IDXW), .D2_IDX_SIZE(IDXW)
    ) dut_b (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_b.slave)
    );

    assign bus_a.content_en = cen;
    assign bus_a.write_en   = wen;
    assign bus_a.addr0      = a0;
    assign bus_a.addr1      = a1;
    assign bus_a.addr2      = a2;
    assign bus_a.write_data = wd;
    assign bus_b.content_en = cen;
    assign bus_b.write_en   = wen;
    assign bus_b.addr0      = a0;
    assign bus_b.addr1      = a1;
    assign bus_b.addr2      = a2;
    assign bus_b.write_data = wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference response for one rising edge, for memory d.
    task automatic modelEdge(input int d, output exp_t e);
        bit oob;
        int idx;
        e = '0;
        if (!reset_n) begin
            model_rd[d] = '0;
        end else if (cen) begin
            oob = (int'(a0) >= d0s[d]) || (int'(a1) >= d1s[d]) || (int'(a2) >= d2s[d]);
            idx = oob ? 0 : (int'(a0) * d1s[d] + int'(a1)) * d2s[d] + int'(a2);
            if (!wen) begin
                model_rd[d] = oob ? '0 : model_mem[d][idx];
            end else if (!oob) begin
                model_mem[d][idx] = wd;
            end
            e.done = 1'b1;
            e.oob  = oob;
        end
        e.data = model_rd[d];
    endtask

    // Advance one edge: the model sees exactly what the DUTs sample.
    task automatic step();
        exp_t e;
        @(posedge clk);
        modelEdge(0, e);
        q_a.push_back(e);
        modelEdge(1, e);
        q_b.push_back(e);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic w, input int x0, input int x1,
                                 input int x2, input logic [WIDTH-1:0] data);
        cen = c;
        wen = w;
        a0  = IDXW'(x0);
        a1  = IDXW'(x1);
        a2  = IDXW'(x2);
        wd  = data;
        step();
    endtask

    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            checkOutput("a.done", WIDTH'(bus_a.done), WIDTH'(ea.done));
            checkOutput("a.oob_error", WIDTH'(bus_a.oob_error), WIDTH'(ea.oob));
            checkOutput("a.read_data", bus_a.read_data, ea.data);
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            checkOutput("b.done", WIDTH'(bus_b.done), WIDTH'(eb.done));
            checkOutput("b.oob_error", WIDTH'(bus_b.oob_error), WIDTH'(eb.oob));
            checkOutput("b.read_data", bus_b.read_data, eb.data);
        end
    end

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, ".a.done"}, WIDTH'(bus_a.done), '0);
        checkOutput({tag, ".a.oob_error"}, WIDTH'(bus_a.oob_error), '0);
        checkOutput({tag, ".a.read_data"}, bus_a.read_data, '0);
        checkOutput({tag, ".b.done"}, WIDTH'(bus_b.done), '0);
        checkOutput({tag, ".b.oob_error"}, WIDTH'(bus_b.oob_error), '0);
        checkOutput({tag, ".b.read_data"}, bus_b.read_data, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        d0s[0] = 16; d1s[0] = 16; d2s[0] = 16;
        d0s[1] = 12; d1s[1] = 16; d2s[1] = 10;
        model_rd[0] = '0;
        model_rd[1] = '0;
        cen = 1'b0;
        wen = 1'b0;
        a0 = '0; a1 = '0; a2 = '0;
        wd = '0;

        // Power-up reset
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1 checkZeroOutputs("reset");
        step();
        step();
        reset_n = 1'b1;

        $display("[TB] basic write/read at (3,5,7)");
        applyStimulus(1'b1, 1'b1, 3, 5, 7, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 3, 5, 7, 32'h0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 32'h0);

        $display("[TB] back-to-back stream");
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, 0, 0, k, WIDTH'(k));
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, 0, 0, k, 32'h0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 32'h0);

        $display("[TB] boundary and out-of-bounds");
        applyStimulus(1'b1, 1'b1, 11, 0, 9, 32'h55);
        applyStimulus(1'b1, 1'b1, 12, 0, 0, 32'hAA);
        applyStimulus(1'b1, 1'b0, 12, 0, 0, 32'h0);
        applyStimulus(1'b1, 1'b0, 11, 0, 9, 32'h0);
        applyStimulus(1'b1, 1'b0, 0, 15, 10, 32'h0);
        applyStimulus(1'b1, 1'b1, 15, 15, 15, 32'hFFFF0001);
        applyStimulus(1'b1, 1'b0, 15, 15, 15, 32'h0);

        $display("[TB] idle hold");
        applyStimulus(1'b1, 1'b1, 2, 2, 2, 32'h1234);
        applyStimulus(1'b1, 1'b0, 2, 2, 2, 32'h0);
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b0, k[0], k, 2, 2, 32'hBAD0_0000 | WIDTH'(k));
        applyStimulus(1'b1, 1'b0, 2, 2, 2, 32'h0);
        applyStimulus(1'b1, 1'b0, 1, 2, 2, 32'h0);
        applyStimulus(1'b1, 1'b0, 3, 5, 7, 32'h0);

        $display("[TB] reset during write burst");
        applyStimulus(1'b1, 1'b1, 1, 1, 0, 32'h100);
        applyStimulus(1'b1, 1'b1, 1, 1, 1, 32'h101);
        applyStimulus(1'b1, 1'b1, 1, 1, 3, 32'h103);
        reset_n = 1'b0;
        q_a.delete();
        q_b.delete();
        model_rd[0] = '0;
        model_rd[1] = '0;
        #1 checkZeroOutputs("midreset");
        applyStimulus(1'b1, 1'b1, 1, 1, 1, 32'hBADBAD);
        applyStimulus(1'b1, 1'b1, 1, 1, 3, 32'hBADBAD);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1, 1, 0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1, 1, 1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1, 1, 3, 32'h0);
        applyStimulus(1'b1, 1'b0, 0, 0, 5, 32'h0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 32'h0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 32'h0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
